// File: rtl/b9_vector_shuttle_if.sv
`default_nettype none
// ============================================================================
// Module      : b9_vector_shuttle_if
// Description : Byte-stream and b9-bus signal bundle for the vector shuttle.
//               master = host/harness side, slave = shuttle side.
// Revision    : 1.0 - initial release
// ============================================================================
interface b9_vector_shuttle_if #(
   parameter int IN_W  = 41,
   parameter int OUT_W = 21
) ();
   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  vec_out;
   logic [OUT_W-1:0] resp_in;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             pad_err;

   modport master (
      output in_data, in_valid, resp_in, out_ready,
      input  in_ready, vec_out, out_data, out_valid, busy, pad_err
   );

   modport slave (
      input  in_data, in_valid, resp_in, out_ready,
      output in_ready, vec_out, out_data, out_valid, busy, pad_err
   );
endinterface
`default_nettype wire

// File: rtl/b9_vector_shuttle.sv
`default_nettype none
// ============================================================================
// Module      : b9_vector_shuttle
// Description : Assembles IN_W-bit vectors from an LSB-first byte stream,
//               drives them to a b9 instance, captures the OUT_W-bit response
//               SETTLE cycles after the vector update and streams it back out
//               LSB-first as bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module b9_vector_shuttle #(
   parameter int IN_W   = 41,
   parameter int OUT_W  = 21,
   parameter int SETTLE = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   b9_vector_shuttle_if.slave    bus
);

   localparam int NB_IN     = (IN_W + 7) / 8;
   localparam int NB_OUT    = (OUT_W + 7) / 8;
   localparam int IN_CNT_W  = $clog2(NB_IN + 1);
   localparam int OUT_CNT_W = $clog2(NB_OUT + 1);
   localparam int RESP_W    = NB_OUT * 8;
   // Number of real vector bits carried by the last input byte.
   localparam int PAD_SHIFT = IN_W - 8 * (NB_IN - 1);

   localparam logic [7:0]           PAD_MASK    = 8'(16'h00FF << PAD_SHIFT);
   localparam logic [IN_CNT_W-1:0]  IN_LAST     = IN_CNT_W'(NB_IN - 1);
   localparam logic [OUT_CNT_W-1:0] OUT_LAST    = OUT_CNT_W'(NB_OUT - 1);
   localparam logic [3:0]           SETTLE_INIT = 4'(SETTLE - 1);

   localparam logic [1:0] S_LOAD  = 2'd0;
   localparam logic [1:0] S_APPLY = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_SEND  = 2'd3;

   logic [1:0]           state_q,   state_d;
   logic [IN_CNT_W-1:0]  in_cnt_q,  in_cnt_d;
   logic [OUT_CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic [IN_W-1:0]      staging_q, staging_d;
   logic [IN_W-1:0]      vec_q,     vec_d;
   logic [RESP_W-1:0]    resp_q,    resp_d;
   logic [3:0]           settle_q,  settle_d;
   logic                 pad_err_q, pad_err_d;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_LOAD;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         staging_q <= '0;
         vec_q     <= '0;
         resp_q    <= '0;
         settle_q  <= '0;
         pad_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         staging_q <= staging_d;
         vec_q     <= vec_d;
         resp_q    <= resp_d;
         settle_q  <= settle_d;
         pad_err_q <= pad_err_d;
      end
   end

   // Next-state selection: load bytes, apply, settle, send response.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD:  if (bus.in_valid && (in_cnt_q == IN_LAST)) state_d = S_APPLY;
         S_APPLY: state_d = S_WAIT;
         S_WAIT:  if (settle_q == 4'd0) state_d = S_SEND;
         S_SEND:  if (bus.out_ready && (out_cnt_q == OUT_LAST)) state_d = S_LOAD;
         default: state_d = S_LOAD;
      endcase
   end

   // Datapath updates: byte staging, vector apply, settle count, response shift.
   always_comb begin
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      staging_d = staging_q;
      vec_d     = vec_q;
      resp_d    = resp_q;
      settle_d  = settle_q;
      pad_err_d = pad_err_q;
      case (state_q)
         S_LOAD: begin
            if (bus.in_valid) begin
               // Bits beyond IN_W-1 of the last byte have no staging home.
               for (int b = 0; b < IN_W; b++) begin
                  if (IN_CNT_W'(b / 8) == in_cnt_q) staging_d[b] = bus.in_data[b % 8];
               end
               if (in_cnt_q == IN_LAST) begin
                  in_cnt_d = '0;
                  if ((bus.in_data & PAD_MASK) != 8'd0) pad_err_d = 1'b1;
               end else begin
                  in_cnt_d = in_cnt_q + 1'b1;
               end
            end
         end
         S_APPLY: begin
            vec_d    = staging_q;
            settle_d = SETTLE_INIT;
         end
         S_WAIT: begin
            if (settle_q == 4'd0) begin
               resp_d              = '0;
               resp_d[OUT_W-1:0]   = bus.resp_in;
            end else begin
               settle_d = settle_q - 4'd1;
            end
         end
         S_SEND: begin
            if (bus.out_ready) begin
               resp_d = resp_q >> 8;
               if (out_cnt_q == OUT_LAST) out_cnt_d = '0;
               else                       out_cnt_d = out_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Outputs depend on registered state only, never on in_valid/out_ready.
   always_comb begin
      bus.in_ready  = (state_q == S_LOAD);
      bus.out_valid = (state_q == S_SEND);
      bus.busy      = !((state_q == S_LOAD) && (in_cnt_q == '0));
      bus.out_data  = resp_q[7:0];
      bus.vec_out   = vec_q;
      bus.pad_err   = pad_err_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_b9_vector_shuttle.sv
`default_nettype none
// ============================================================================
// Module      : tb_b9_vector_shuttle
// Description : Directed-vector self-checking bench for b9_vector_shuttle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_b9_vector_shuttle;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   b9_vector_shuttle_if #(.IN_W(41), .OUT_W(21)) bus ();

   b9_vector_shuttle #(.IN_W(41), .OUT_W(21), .SETTLE(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         check("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
         bus.in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 bus.in_valid = 1'b0;
      end
   endtask

   task automatic recv_byte(input string tag, input logic [7:0] exp);
      int n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.out_valid) begin
         check({tag, "_timeout"}, {63'd0, bus.out_valid}, 64'd1);
      end else begin
         check(tag, {56'd0, bus.out_data}, {56'd0, exp});
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1 bus.out_ready = 1'b0;
      end
   endtask

   initial begin
      int hi_cnt;
      logic [7:0] v1 [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01};
      logic [7:0] v2 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h81};
      logic [7:0] v3 [6] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      logic [7:0] v4 [6] = '{8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h00};

      rst           = 1'b1;
      bus.in_data   = 8'h00;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.resp_in   = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_vec_out",   {23'd0, bus.vec_out}, 64'd0);
      check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst_in_ready",  {63'd0, bus.in_ready}, 64'd1);
      check("rst_pad_err",   {63'd0, bus.pad_err}, 64'd0);
      check("rst_busy",      {63'd0, bus.busy}, 64'd0);
      check("rst_out_data",  {56'd0, bus.out_data}, 64'd0);
      rst = 1'b0;

      // Basic vector and response
      bus.resp_in = 21'h1ABCDE;
      send_byte(v1[0]);
      check("busy_mid_load", {63'd0, bus.busy}, 64'd1);
      for (int i = 1; i < 6; i++) send_byte(v1[i]);
      check("apply_in_ready", {63'd0, bus.in_ready}, 64'd0);
      @(posedge clk); #1;
      check("v1_vec_out", {23'd0, bus.vec_out}, 64'h1_0504030201);
      recv_byte("v1_b0", 8'hDE);
      recv_byte("v1_b1", 8'hBC);
      recv_byte("v1_b2", 8'h1A);
      @(negedge clk);
      check("v1_in_ready_after", {63'd0, bus.in_ready}, 64'd1);
      check("v1_busy_after",     {63'd0, bus.busy}, 64'd0);
      check("v1_out_valid_after",{63'd0, bus.out_valid}, 64'd0);
      check("v1_pad_err",        {63'd0, bus.pad_err}, 64'd0);

      // Padding error plus output back-pressure
      bus.resp_in = 21'h12C3A5;
      for (int i = 0; i < 6; i++) send_byte(v2[i]);
      @(posedge clk); #1;
      check("v2_vec_out", {23'd0, bus.vec_out}, 64'h1_5544332211);
      check("v2_pad_err", {63'd0, bus.pad_err}, 64'd1);
      recv_byte("v2_b0", 8'hA5);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
         check("stall_out_data",  {56'd0, bus.out_data}, 64'hC3);
      end
      recv_byte("v2_b1", 8'hC3);
      recv_byte("v2_b2", 8'h12);

      // Capture timing: change 1 cycle before capture edge, then after it
      bus.resp_in = 21'h0AAAAA;
      for (int i = 0; i < 6; i++) send_byte(v3[i]);
      @(posedge clk);
      @(posedge clk);
      #1 bus.resp_in = 21'h055555;
      @(posedge clk);
      #1 bus.resp_in = 21'h1FFFFF;
      check("v3_vec_out",      {23'd0, bus.vec_out}, 64'h0FF);
      check("v3_pad_err_hold", {63'd0, bus.pad_err}, 64'd1);
      recv_byte("v3_b0", 8'h55);
      recv_byte("v3_b1", 8'h55);
      recv_byte("v3_b2", 8'h05);

      // Reset mid-load discards partial bytes
      for (int i = 0; i < 3; i++) send_byte(8'hAA + 8'(i));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("mid_rst_busy",    {63'd0, bus.busy}, 64'd0);
      check("mid_rst_pad_err", {63'd0, bus.pad_err}, 64'd0);
      check("mid_rst_vec_out", {23'd0, bus.vec_out}, 64'd0);
      bus.resp_in = 21'h0D0E0F;
      for (int i = 0; i < 6; i++) send_byte(v4[i]);
      @(posedge clk); #1;
      check("v4_vec_out", {23'd0, bus.vec_out}, 64'h0_0A09080706);
      recv_byte("v4_b0", 8'h0F);
      recv_byte("v4_b1", 8'h0E);
      recv_byte("v4_b2", 8'h0D);
      hi_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.out_valid) hi_cnt++;
      end
      check("v4_no_extra_byte", 64'(hi_cnt), 64'd0);
      check("v4_in_ready_end",  {63'd0, bus.in_ready}, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
